// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared constants, FSM state type and lane decode helper for tdm_demux8
//
// Purpose:
//   Common definitions for the 8-lane TDM demultiplexer:
//     LANES   number of lanes in one frame
//     SLOT_W  width of the slot index
//     state_e alignment FSM states (IDLE = unaligned, RECV = aligned)
//   lane_onehot() turns a slot index into write enables for the
//   shadow lanes 0..LANES-2. Lane LANES-1 never lands in the shadow:
//   it goes straight into dout together with the shadow contents.
package tdm_demux_pkg;

  localparam int LANES  = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  // One-hot shadow-lane enable for a slot; the last slot yields all zeros.
  function automatic logic [LANES-2:0] lane_onehot(input logic [SLOT_W-1:0] s);
    logic [LANES-2:0] en;
    en = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      if (s == SLOT_W'(k)) begin
        en[k] = 1'b1;
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// rtl/tdm_demux8_if.sv - sample input and frame output bundle of tdm_demux8
//
// Purpose:
//   Groups the serial sample stream and the assembled-frame outputs.
// Signals:
//   din        [W-1:0]        serial lane sample
//   din_valid                 qualifies din and sync
//   sync                      frame-start marker (meaningful only with din_valid)
//   dout       [LANES*W-1:0]  assembled frame, lane k at [k*W +: W]
//   dout_valid                one-cycle pulse when dout is updated
//   slot       [SLOT_W-1:0]   lane index the next accepted sample fills
//   err                       one-cycle pulse on a frame-alignment error
// Modports:
//   master  the sample producer / frame consumer
//   slave   the demultiplexer
interface tdm_demux8_if
  import tdm_demux_pkg::*;
#(
  parameter int W = 1
);

  logic [W-1:0]       din;
  logic               din_valid;
  logic               sync;
  logic [LANES*W-1:0] dout;
  logic               dout_valid;
  logic [SLOT_W-1:0]  slot;
  logic               err;

  modport master (
    output din,
    output din_valid,
    output sync,
    input  dout,
    input  dout_valid,
    input  slot,
    input  err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  sync,
    output dout,
    output dout_valid,
    output slot,
    output err
  );

endinterface

// File: rtl/demux_slot_ctr.sv
// rtl/demux_slot_ctr.sv - lane slot counter with sync clear-to-1 and wrap flag
//
// Purpose:
//   Tracks which lane the next accepted sample fills. A sync sample is
//   itself lane 0, so clear_i loads 1 (the lane after it). Incrementing
//   past the last lane wraps naturally to 0 through the SLOT_W-bit width.
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset, forces slot to 0
//   clear_i  sync sample accepted: slot becomes 1 (has priority over inc_i)
//   inc_i    data sample accepted while aligned: slot advances modulo LANES
//   slot_o   current slot index (registered)
//   wrap_o   slot is at the last lane, the next increment completes a frame
module demux_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              wrap_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign wrap_o = (slot_q == SLOT_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-lane TDM demultiplexer with sync alignment and error flag
//
// Purpose:
//   Collects a serial stream of W-bit samples into 8-lane frames. A sync
//   sample aligns the block and is stored as lane 0. Lanes 0..6 build up
//   in a shadow register; the lane-7 sample loads the whole frame into
//   dout at once, so dout never shows a partial frame. Frames then follow
//   back to back without further sync. A sync arriving mid-frame flags
//   err, drops the partial frame and restarts alignment on that sample.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  tdm_demux8_if slave modport (din/din_valid/sync in,
//        dout/dout_valid/slot/err out, all outputs registered)
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int W = 1
)
(
  input  logic        clk,
  input  logic        rst,
  tdm_demux8_if.slave bus
);

  localparam int SH_W = (LANES - 1) * W;

  state_e             state_q;
  state_e             state_d;
  logic [SH_W-1:0]    shadow_q;
  logic [SH_W-1:0]    shadow_d;
  logic [LANES*W-1:0] dout_q;
  logic [LANES*W-1:0] dout_d;
  logic               dout_valid_q;
  logic               dout_valid_d;
  logic               err_q;
  logic               err_d;

  logic               ctr_clear;
  logic               ctr_inc;
  logic [SLOT_W-1:0]  slot;
  logic               wrap;
  logic [LANES-2:0]   lane_en;

  demux_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (ctr_clear),
    .inc_i   (ctr_inc),
    .slot_o  (slot),
    .wrap_o  (wrap)
  );

  // Slot-to-lane write decode for the shadow lanes.
  assign lane_en = lane_onehot(slot);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    ctr_clear    = 1'b0;
    ctr_inc      = 1'b0;

    if (bus.din_valid) begin
      if (bus.sync) begin
        // Sync is lane 0 of a new frame in either state. Mid-frame it is
        // an alignment error; the stale shadow lanes are wiped so the
        // dropped partial frame cannot leak into the next one.
        state_d            = RECV;
        ctr_clear          = 1'b1;
        err_d              = (state_q == RECV) && (slot != '0);
        shadow_d           = '0;
        shadow_d[0 +: W]   = bus.din;
      end else if (state_q == RECV) begin
        ctr_inc = 1'b1;
        if (wrap) begin
          dout_d       = {bus.din, shadow_q};
          dout_valid_d = 1'b1;
        end else begin
          for (int k = 0; k < LANES - 1; k++) begin
            if (lane_en[k]) begin
              shadow_d[k*W +: W] = bus.din;
            end
          end
        end
      end
      // Unaligned samples without sync are simply dropped.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - directed self-checking bench for tdm_demux8 with W=1
module tb_tdm_demux8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   dv_cnt;
  int   err_cnt;

  tdm_demux8_if #(.W(1)) bus ();

  tdm_demux8 #(.W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dv_cnt  = 0;
    err_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic send(input logic d, input logic s);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.sync      = s;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_lanes(input logic [7:0] f, input int lo, input int hi,
                            input bit sync_first, input int max_gap);
    for (int k = lo; k <= hi; k++) begin
      send(f[k], sync_first && (k == lo));
      if (max_gap > 0 && k != hi) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", bus.dout_valid); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] f;
    f = 8'hA5;
    send_lanes(f, 0, 6, 1'b1, 0);
    total++; if (bus.slot !== 3'd7) begin bad++; $display("FAIL single_slot7 got=%0d exp=7", bus.slot); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL single_early_dv got=%b exp=0", bus.dout_valid); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL single_partial_dout got=%h exp=00", bus.dout); end
    send(f[7], 1'b0);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL single_dv got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'hA5) begin bad++; $display("FAIL single_dout got=%h exp=a5", bus.dout); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL single_slot_wrap got=%0d exp=0", bus.slot); end
    idle(1);
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL single_dv_pulse got=%b exp=0", bus.dout_valid); end
    total++; if (bus.dout !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h exp=a5", bus.dout); end
  endtask

  task automatic test_back_to_back();
    int base;
    int t1;
    base = dv_cnt;
    send_lanes(8'h3C, 0, 7, 1'b1, 0);
    t1 = cyc;
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_dv1 got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'h3C) begin bad++; $display("FAIL b2b_dout1 got=%h exp=3c", bus.dout); end
    send_lanes(8'hC3, 0, 6, 1'b0, 0);
    total++; if (bus.dout !== 8'h3C) begin bad++; $display("FAIL b2b_hold got=%h exp=3c", bus.dout); end
    send_lanes(8'hC3, 7, 7, 1'b0, 0);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_dv2 got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'hC3) begin bad++; $display("FAIL b2b_dout2 got=%h exp=c3", bus.dout); end
    total++; if (cyc - t1 !== 8) begin bad++; $display("FAIL b2b_spacing got=%0d exp=8", cyc - t1); end
    idle(1);
    total++; if (dv_cnt - base !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", dv_cnt - base); end
  endtask

  task automatic test_no_sync();
    int db;
    int eb;
    test_reset();
    db = dv_cnt;
    eb = err_cnt;
    send_lanes(8'hFF, 0, 7, 1'b0, 0);
    send_lanes(8'h5A, 0, 7, 1'b0, 0);
    idle(1);
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL nosync_dout got=%h exp=00", bus.dout); end
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL nosync_slot got=%0d exp=0", bus.slot); end
    total++; if (dv_cnt - db !== 0) begin bad++; $display("FAIL nosync_dv got=%0d exp=0", dv_cnt - db); end
    total++; if (err_cnt - eb !== 0) begin bad++; $display("FAIL nosync_err got=%0d exp=0", err_cnt - eb); end
  endtask

  task automatic test_resync_err();
    int db;
    int eb;
    logic [7:0] f;
    f = 8'hFF;
    db = dv_cnt;
    eb = err_cnt;
    send_lanes(8'h0F, 0, 3, 1'b1, 0);
    total++; if (bus.slot !== 3'd4) begin bad++; $display("FAIL resync_slot4 got=%0d exp=4", bus.slot); end
    send(f[0], 1'b1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b exp=1", bus.err); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL resync_dv_excl got=%b exp=0", bus.dout_valid); end
    total++; if (bus.slot !== 3'd1) begin bad++; $display("FAIL resync_slot1 got=%0d exp=1", bus.slot); end
    send(f[1], 1'b0);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL resync_err_pulse got=%b exp=0", bus.err); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL resync_no_partial got=%h exp=00", bus.dout); end
    send_lanes(f, 2, 7, 1'b0, 0);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL resync_dv got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'hFF) begin bad++; $display("FAIL resync_dout got=%h exp=ff", bus.dout); end
    idle(1);
    total++; if (err_cnt - eb !== 1) begin bad++; $display("FAIL resync_err_count got=%0d exp=1", err_cnt - eb); end
    total++; if (dv_cnt - db !== 1) begin bad++; $display("FAIL resync_dv_count got=%0d exp=1", dv_cnt - db); end
  endtask

  task automatic test_gaps();
    int db;
    int eb;
    db = dv_cnt;
    eb = err_cnt;
    send_lanes(8'h5A, 0, 7, 1'b1, 3);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL gaps_dv got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'h5A) begin bad++; $display("FAIL gaps_dout got=%h exp=5a", bus.dout); end
    idle(3);
    total++; if (dv_cnt - db !== 1) begin bad++; $display("FAIL gaps_dv_count got=%0d exp=1", dv_cnt - db); end
    total++; if (err_cnt - eb !== 0) begin bad++; $display("FAIL gaps_err_count got=%0d exp=0", err_cnt - eb); end
    total++; if (bus.dout !== 8'h5A) begin bad++; $display("FAIL gaps_hold got=%h exp=5a", bus.dout); end
  endtask

  task automatic test_async_reset();
    int db;
    send_lanes(8'h81, 0, 5, 1'b1, 0);
    total++; if (bus.slot !== 3'd6) begin bad++; $display("FAIL arst_slot6 got=%0d exp=6", bus.slot); end
    db = dv_cnt;
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL arst_slot got=%0d exp=0", bus.slot); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h exp=00", bus.dout); end
    total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL arst_dv got=%b exp=0", bus.dout_valid); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b exp=0", bus.err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    total++; if (dv_cnt - db !== 0) begin bad++; $display("FAIL arst_no_pulse got=%0d exp=0", dv_cnt - db); end
    send_lanes(8'h81, 0, 7, 1'b1, 0);
    total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL arst_dv_after got=%b exp=1", bus.dout_valid); end
    total++; if (bus.dout !== 8'h81) begin bad++; $display("FAIL arst_dout_after got=%h exp=81", bus.dout); end
    idle(1);
    total++; if (dv_cnt - db !== 1) begin bad++; $display("FAIL arst_dv_count got=%0d exp=1", dv_cnt - db); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_no_sync();
    test_resync_err();
    test_gaps();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 SHALL have parameter W, default 1, giving the per-lane data width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port din, input, W, the serial lane sample.
REQ-005 SHALL have port din_valid, input, 1, which qualifies din and sync.
REQ-006 SHALL have port sync, input, 1, the frame-start marker, sampled only when din_valid=1.
REQ-007 SHALL have port dout, output, 8*W, the assembled frame, with lane k at bits [k*W +: W].
REQ-008 SHALL have port dout_valid, output, 1, a one-cycle pulse when dout is updated.
REQ-009 SHALL have port slot, output, 3, the lane index the next accepted sample will fill.
REQ-010 SHALL have port err, output, 1, a one-cycle pulse on a frame-alignment error.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE (unaligned) and RECV (aligned).
REQ-012 In IDLE, a cycle with din_valid=1 and sync=0 SHALL be discarded, leaving slot, dout and err unchanged.
REQ-013 In any state, din_valid=1 and sync=1 SHALL store din into lane 0, set slot to 1 and enter RECV.
REQ-014 In RECV, din_valid=1 with sync=0 SHALL store din into lane slot and increment slot modulo 8.
REQ-015 din_valid=0 SHALL hold all state, and SHALL NOT limit the gap length between samples.
REQ-016 Lanes 0..6 SHALL be held in an internal shadow register, so dout never shows a partial frame.
REQ-017 On the edge accepting lane 7, dout SHALL load {din, shadow lanes 6..0} and dout_valid SHALL be 1 for exactly the following cycle.
REQ-018 Latency from the lane-7 sample presented to dout_valid high SHALL be one clock.
REQ-019 After lane 7, slot SHALL wrap to 0 and the FSM SHALL stay in RECV, so back-to-back frames need no sync.
REQ-020 Sync accepted in RECV with slot not equal to 0 SHALL pulse err for one cycle, discard the partial frame, and restart at lane 0 per REQ-013.
REQ-021 Sync accepted in RECV with slot=0 SHALL be a normal, error-free frame start.
REQ-022 dout SHALL hold its last frame until the next lane-7 acceptance.
REQ-023 dout_valid and err SHALL NOT assert together; they are mutually exclusive by construction.
REQ-024 All outputs SHALL be driven from registers, with no combinational path from input to output.

Reset
REQ-025 While rst=1, the block SHALL force: state=IDLE, slot=0, shadow=0, dout=0, dout_valid=0, err=0.
REQ-026 rst asserting mid-frame SHALL discard the partial frame with no dout_valid pulse.
REQ-027 After rst deasserts, the first frame SHALL require sync.

Structure
REQ-028 Package tdm_demux_pkg SHALL hold LANES=8, SLOT_W=3 and the FSM state enum (IDLE, RECV).
REQ-029 Slot counting and wrap SHALL live in sub-module demux_slot_ctr, which has clear-to-1 (sync), increment and wrap-flag outputs.
REQ-030 The lane write-decode (the slot-to-lane-enable demux) SHALL be in the top level.

Verification
REQ-031 Reset, then a sync frame 8'hA5 with W=1 (LSB first), fed contiguously: -> dout=8'hA5 and dout_valid high one cycle after lane 7, slot=0.
REQ-032 Two contiguous frames 8'h3C then 8'hC3 with sync only on the first: -> two dout_valid pulses 8 cycles apart, dout=8'h3C then 8'hC3.
REQ-033 Samples without sync after reset: -> dout stays 0, slot stays 0, no dout_valid, no err.
REQ-034 Sync frame; sync reasserted at slot=4; a full frame 8'hFF follows: -> err pulse at slot 4, no output for the partial frame, then dout=8'hFF.
REQ-035 Frame 8'h5A with din_valid gaps of 0 to 3 random cycles: -> dout=8'h5A and a single dout_valid pulse.
REQ-036 rst asserted asynchronously (off clock edge) at slot=6, then released and a sync frame 8'h81 is sent: -> immediate reset values, no pulse, then dout=8'h81.
